// File: rtl/audio_out_fifo_if.sv
// Stereo sample handshake bundle: filter-side push port and codec-side write port.
// "master" is the environment (filter + codec); "slave" is the FIFO.
interface audio_out_fifo_if #(
    parameter int DATA_W = 24
);
    logic              in_valid;
    logic [DATA_W-1:0] in_left;
    logic [DATA_W-1:0] in_right;
    logic              in_ready;
    logic              write_ready;
    logic              write;
    logic [DATA_W-1:0] writedata_left;
    logic [DATA_W-1:0] writedata_right;

    modport master (
        output in_valid, in_left, in_right, write_ready,
        input  in_ready, write, writedata_left, writedata_right
    );

    modport slave (
        input  in_valid, in_left, in_right, write_ready,
        output in_ready, write, writedata_left, writedata_right
    );
endinterface

// File: rtl/audio_out_fifo.sv
// First-word-fall-through stereo FIFO between the FIR filters and the codec DAC port.
// Define AUDIO_FIFO_HOLD_LAST_EN to repeat the last drained pair instead of stalling when empty.
module audio_out_fifo #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    audio_out_fifo_if.slave   bus,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic [15:0]       underrun_cnt
);
    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    logic [2*DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0]   wr_ptr_reg;
    logic [ADDR_W-1:0]   rd_ptr_reg;
    logic [ADDR_W:0]     count_reg;
    logic                overflow_reg;
    logic [15:0]         underrun_cnt_reg;
    logic [2*DATA_W-1:0] last_pair_reg;

    logic                full;
    logic                empty;
    logic                push;
    logic                pop;
    logic [2*DATA_W-1:0] head_pair;
    logic [2*DATA_W-1:0] out_pair;

    assign full      = (count_reg == FULL_COUNT);
    assign empty     = (count_reg == '0);
    assign push      = bus.in_valid & ~full;
    assign pop       = bus.write_ready & ~empty;
    assign head_pair = mem[rd_ptr_reg];

    always_comb begin
        out_pair  = head_pair;
        bus.write = pop;
`ifdef AUDIO_FIFO_HOLD_LAST_EN
        // Empty: keep the codec fed with the previous pair; pointers stay put.
        if (empty) begin
            out_pair  = last_pair_reg;
            bus.write = bus.write_ready;
        end
`else
        if (empty) begin
            out_pair = '0;
        end
`endif
    end

    assign bus.in_ready        = ~full;
    assign bus.writedata_left  = out_pair[2*DATA_W-1:DATA_W];
    assign bus.writedata_right = out_pair[DATA_W-1:0];
    assign count               = count_reg;
    assign overflow            = overflow_reg;
    assign underrun_cnt        = underrun_cnt_reg;

    always_ff @(posedge clock) begin
        if (reset && push) begin
            mem[wr_ptr_reg] <= {bus.in_left, bus.in_right};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            count_reg        <= '0;
            overflow_reg     <= 1'b0;
            underrun_cnt_reg <= '0;
            last_pair_reg    <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg    <= rd_ptr_reg + ADDR_W'(1);
                last_pair_reg <= head_pair;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (ADDR_W + 1)'(1);
                2'b01:   count_reg <= count_reg - (ADDR_W + 1)'(1);
                default: count_reg <= count_reg;
            endcase
            if (bus.in_valid && full) begin
                overflow_reg <= 1'b1;
            end
            if (bus.write_ready && empty && (underrun_cnt_reg != 16'hFFFF)) begin
                underrun_cnt_reg <= underrun_cnt_reg + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_audio_out_fifo.sv
// Scoreboard bench for audio_out_fifo: driver queues expected pairs, negedge monitor checks drained pairs.
module tb_audio_out_fifo;
    localparam int DATA_W = 24;
    localparam int DEPTH  = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  count;
    logic        overflow;
    logic [15:0] underrun_cnt;

    always #5 clock = ~clock;

    audio_out_fifo_if #(.DATA_W(DATA_W)) bus ();

    audio_out_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus),
        .count        (count),
        .overflow     (overflow),
        .underrun_cnt (underrun_cnt)
    );

    int          errors = 0;
    int          checks = 0;
    int          pops   = 0;
    logic [47:0] exp_q[$];
    logic [47:0] last_exp = '0;
    logic [47:0] mon_e;

`ifdef AUDIO_FIFO_HOLD_LAST_EN
    localparam logic HOLD = 1'b1;
`else
    localparam logic HOLD = 1'b0;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_pair(input logic [23:0] l, input logic [23:0] r, input bit accept);
        bus.in_valid = 1'b1;
        bus.in_left  = l;
        bus.in_right = r;
        if (accept) exp_q.push_back({l, r});
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        exp_q.delete();
        last_exp = '0;
        repeat (n) tick();
        reset = 1'b1;
    endtask

    // Monitor: every real transfer must match the head of the scoreboard.
    always @(negedge clock) begin
        if (reset && bus.write) begin
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("drain_data", 64'({bus.writedata_left, bus.writedata_right}), 64'(mon_e));
                last_exp = mon_e;
                pops++;
            end else if (HOLD) begin
                chk("hold_last_data", 64'({bus.writedata_left, bus.writedata_right}), 64'(last_exp));
            end else begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got write=1 data=%0h expected write=0 (nothing queued)",
                         {bus.writedata_left, bus.writedata_right});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000ns");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        bus.in_valid    = 1'b0;
        bus.in_left     = '0;
        bus.in_right    = '0;
        bus.write_ready = 1'b0;

        // Reset state
        do_reset(2);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_write", 64'(bus.write), 64'd0);
        chk("rst_wd_left", 64'(bus.writedata_left), 64'd0);
        chk("rst_wd_right", 64'(bus.writedata_right), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_underrun", 64'(underrun_cnt), 64'd0);

        // Ordered drain of five pairs
        for (int k = 1; k <= 5; k++) push_pair(24'(k), 24'hF00000 + 24'(k), 1'b1);
        chk("drain5_count_full", 64'(count), 64'd5);
        chk("drain5_head_left", 64'(bus.writedata_left), 64'd1);
        p0 = pops;
        bus.write_ready = 1'b1;
        repeat (5) tick();
        chk("drain5_count_empty", 64'(count), 64'd0);
        chk("drain5_pops", 64'(pops - p0), 64'd5);
        chk("drain5_write_after", 64'(bus.write), 64'(HOLD));
        bus.write_ready = 1'b0;

        // Full boundary: 17 offers, 16 accepted
        for (int k = 1; k <= 17; k++) begin
            push_pair(24'h000010 + 24'(k), 24'hA00000 + 24'(k), k <= 16);
            if (k == 15) chk("full_in_ready_15", 64'(bus.in_ready), 64'd1);
            if (k == 16) chk("full_in_ready_16", 64'(bus.in_ready), 64'd0);
        end
        chk("full_count", 64'(count), 64'd16);
        chk("full_overflow", 64'(overflow), 64'd1);
        p0 = pops;
        bus.write_ready = 1'b1;
        repeat (16) tick();
        bus.write_ready = 1'b0;
        chk("full_drain_count", 64'(count), 64'd0);
        chk("full_drain_pops", 64'(pops - p0), 64'd16);
        chk("full_overflow_sticky", 64'(overflow), 64'd1);

        // Concurrent push/pop at count=3, pointers wrap
        for (int k = 1; k <= 3; k++) push_pair(24'h000300 + 24'(k), 24'hB00300 + 24'(k), 1'b1);
        chk("conc_count_start", 64'(count), 64'd3);
        bus.write_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = 1'b1;
            bus.in_left  = 24'h000400 + 24'(i);
            bus.in_right = 24'hB00400 + 24'(i);
            exp_q.push_back({bus.in_left, bus.in_right});
            tick();
            chk("conc_count", 64'(count), 64'd3);
        end
        bus.in_valid = 1'b0;
        repeat (3) tick();
        bus.write_ready = 1'b0;
        chk("conc_count_end", 64'(count), 64'd0);
        chk("conc_queue_empty", 64'(exp_q.size()), 64'd0);

        // Underrun counting from a clean reset
        do_reset(1);
        bus.write_ready = 1'b1;
        repeat (10) tick();
        bus.write_ready = 1'b0;
        chk("underrun_10", 64'(underrun_cnt), 64'd10);
        push_pair(24'h000055, 24'hC00055, 1'b1);
        bus.write_ready = 1'b1;
        repeat (3) tick();
        bus.write_ready = 1'b0;
        chk("underrun_12", 64'(underrun_cnt), 64'd12);
        chk("empty_wd_left", 64'(bus.writedata_left), HOLD ? 64'h55 : 64'd0);
        chk("empty_wd_right", 64'(bus.writedata_right), HOLD ? 64'hC00055 : 64'd0);

        // Reset mid-stream
        for (int k = 1; k <= 7; k++) push_pair(24'h000700 + 24'(k), 24'hD00700 + 24'(k), 1'b1);
        chk("mid_count_7", 64'(count), 64'd7);
        bus.write_ready = 1'b1;
        do_reset(1);
        chk("mid_count_0", 64'(count), 64'd0);
        chk("mid_write", 64'(bus.write), 64'(HOLD));
        chk("mid_in_ready", 64'(bus.in_ready), 64'd1);
        bus.write_ready = 1'b0;
        push_pair(24'h123456, 24'h654321, 1'b1);
        chk("mid_new_count", 64'(count), 64'd1);
        chk("mid_new_left", 64'(bus.writedata_left), 64'h123456);
        chk("mid_new_right", 64'(bus.writedata_right), 64'h654321);
        bus.write_ready = 1'b1;
        tick();
        bus.write_ready = 1'b0;
        chk("mid_final_count", 64'(count), 64'd0);
        chk("mid_queue_empty", 64'(exp_q.size()), 64'd0);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
